// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - request bundle and registered write port of the register-file write arbiter
interface regfile_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  localparam int GW = $clog2(N_REQ);

  logic                   stall;
  logic [N_REQ-1:0]       req_valid;
  logic [5*N_REQ-1:0]     req_addr;
  logic [WIDTH*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   wr_ena;
  logic [4:0]             wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic [GW-1:0]          last_grant;

  modport master (
    output stall,
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready,
    input  wr_ena,
    input  wr_addr,
    input  wr_data,
    input  last_grant
  );

  modport slave (
    input  stall,
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready,
    output wr_ena,
    output wr_addr,
    output wr_data,
    output last_grant
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing the single register-file write port
module regfile_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int GW = $clog2(N_REQ);

  logic [GW-1:0]    last_grant_q, last_grant_d;
  logic             wr_ena_q, wr_ena_d;
  logic [4:0]       wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

  logic [GW-1:0]    grant_idx;
  logic             grant_any;
  logic             grant_en;
  logic [N_REQ-1:0] ready;
  logic [4:0]       sel_addr;
  logic [WIDTH-1:0] sel_data;

  function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return GW'(sum);
  endfunction

  // Walk the ring from farthest to nearest so the nearest valid requester after last_grant wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (bus.req_valid[rr_index(last_grant_q, k)]) begin
        grant_idx = rr_index(last_grant_q, k);
        grant_any = 1'b1;
      end
    end
  end

  assign grant_en = grant_any & ~bus.stall & ~rst;
  assign ready    = grant_en ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  assign sel_addr = bus.req_addr[5*int'(grant_idx) +: 5];
  assign sel_data = bus.req_data[WIDTH*int'(grant_idx) +: WIDTH];

  // Register 0 writes still complete the handshake and advance priority; only wr_ena is suppressed.
  always_comb begin
    last_grant_d = last_grant_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_ena_d     = 1'b0;
    if (grant_en) begin
      last_grant_d = grant_idx;
      wr_addr_d    = sel_addr;
      wr_data_d    = sel_data;
      wr_ena_d     = (sel_addr != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GW'(N_REQ - 1);
      wr_ena_q     <= 1'b0;
      wr_addr_q    <= 5'd0;
      wr_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_ena_q     <= wr_ena_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.wr_ena     = wr_ena_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.last_grant = last_grant_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - vector table plus randomized reference-model check of the write arbiter
module tb_regfile_write_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam logic [19:0]  A_DEF = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [19:0]  A_ONE = {5'd0, 5'd0, 5'd5, 5'd0};
  localparam logic [19:0]  A_Z   = {5'd4, 5'd0, 5'd2, 5'd1};
  localparam logic [19:0]  A_7   = {5'd7, 5'd3, 5'd2, 5'd1};
  localparam logic [127:0] D_DEF = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
  localparam logic [127:0] D_ONE = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
  localparam logic [127:0] D_Z   = {32'hD3D3D3D3, 32'h12345678, 32'hD1D1D1D1, 32'hD0D0D0D0};
  localparam logic [31:0]  D0 = 32'hD0D0D0D0;
  localparam logic [31:0]  D1 = 32'hD1D1D1D1;
  localparam logic [31:0]  D2 = 32'hD2D2D2D2;
  localparam logic [31:0]  D3 = 32'hD3D3D3D3;

  typedef struct {
    logic         rst;
    logic         stall;
    logic [3:0]   valid;
    logic [19:0]  addr;
    logic [127:0] data;
    logic [3:0]   exp_ready;
    logic         chk_regs;
    logic         exp_ena;
    logic [4:0]   exp_addr;
    logic [31:0]  exp_data;
    logic [1:0]   exp_last;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  int          m_last;
  logic        m_ena;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  vec_t tbl[29];

  regfile_write_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  regfile_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic r, input logic s, input logic [3:0] v,
                              input logic [19:0] a, input logic [127:0] d,
                              input logic [3:0] er, input logic cr, input logic ee,
                              input logic [4:0] ea, input logic [31:0] ed, input logic [1:0] el);
    vec_t t;
    t.rst = r; t.stall = s; t.valid = v; t.addr = a; t.data = d;
    t.exp_ready = er; t.chk_regs = cr; t.exp_ena = ee;
    t.exp_addr = ea; t.exp_data = ed; t.exp_last = el;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [3:0] v,
                       input logic [19:0] a, input logic [127:0] d);
    rst           = r;
    bus.stall     = s;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
  endtask

  // Rotating search order: requesters after the last winner, in ring order.
  function automatic int model_pick(input logic [3:0] v, input int last);
    int order[$];
    for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic int model_grant();
    if (rst || bus.stall) return -1;
    return model_pick(bus.req_valid, m_last);
  endfunction

  task automatic model_edge();
    int g;
    g = model_grant();
    if (rst) begin
      m_ena = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_last = N - 1;
    end else if (g >= 0) begin
      m_last = g;
      m_addr = bus.req_addr[5*g +: 5];
      m_data = bus.req_data[32*g +: 32];
      m_ena  = (m_addr != 5'd0);
    end else begin
      m_ena = 1'b0;
    end
  endtask

  initial begin
    int g;
    logic [3:0]   exp_ready;
    logic [19:0]  ra;
    logic [127:0] rd;

    n_checks = 0;
    n_err    = 0;
    m_last   = N - 1;
    m_ena    = 1'b0;
    m_addr   = 5'd0;
    m_data   = 32'd0;

    tbl[0]  = mk(1, 0, 4'b0000, A_DEF, D_DEF, 4'b0000, 0, 0, 5'd0, 32'h0, 2'd3);
    tbl[1]  = mk(1, 0, 4'b0000, A_DEF, D_DEF, 4'b0000, 1, 0, 5'd0, 32'h0, 2'd3);
    tbl[2]  = mk(0, 0, 4'b0000, A_DEF, D_DEF, 4'b0000, 1, 0, 5'd0, 32'h0, 2'd3);
    tbl[3]  = mk(0, 0, 4'b0010, A_ONE, D_ONE, 4'b0010, 1, 0, 5'd0, 32'h0, 2'd3);
    tbl[4]  = mk(0, 0, 4'b0000, A_ONE, D_ONE, 4'b0000, 1, 1, 5'd5, 32'hDEADBEEF, 2'd1);
    tbl[5]  = mk(0, 0, 4'b0000, A_ONE, D_ONE, 4'b0000, 1, 0, 5'd5, 32'hDEADBEEF, 2'd1);
    tbl[6]  = mk(1, 0, 4'b0000, A_DEF, D_DEF, 4'b0000, 1, 0, 5'd5, 32'hDEADBEEF, 2'd1);
    tbl[7]  = mk(0, 0, 4'b1111, A_DEF, D_DEF, 4'b0001, 1, 0, 5'd0, 32'h0, 2'd3);
    tbl[8]  = mk(0, 0, 4'b1111, A_DEF, D_DEF, 4'b0010, 1, 1, 5'd1, D0, 2'd0);
    tbl[9]  = mk(0, 0, 4'b1111, A_DEF, D_DEF, 4'b0100, 1, 1, 5'd2, D1, 2'd1);
    tbl[10] = mk(0, 0, 4'b1111, A_DEF, D_DEF, 4'b1000, 1, 1, 5'd3, D2, 2'd2);
    tbl[11] = mk(0, 0, 4'b1111, A_DEF, D_DEF, 4'b0001, 1, 1, 5'd4, D3, 2'd3);
    tbl[12] = mk(0, 0, 4'b0000, A_DEF, D_DEF, 4'b0000, 1, 1, 5'd1, D0, 2'd0);
    tbl[13] = mk(0, 0, 4'b0100, A_Z,   D_Z,   4'b0100, 1, 0, 5'd1, D0, 2'd0);
    tbl[14] = mk(0, 0, 4'b0000, A_Z,   D_Z,   4'b0000, 1, 0, 5'd0, 32'h12345678, 2'd2);
    tbl[15] = mk(1, 0, 4'b0000, A_DEF, D_DEF, 4'b0000, 1, 0, 5'd0, 32'h12345678, 2'd2);
    tbl[16] = mk(0, 1, 4'b1001, A_DEF, D_DEF, 4'b0000, 1, 0, 5'd0, 32'h0, 2'd3);
    tbl[17] = mk(0, 1, 4'b1001, A_DEF, D_DEF, 4'b0000, 1, 0, 5'd0, 32'h0, 2'd3);
    tbl[18] = mk(0, 1, 4'b1001, A_DEF, D_DEF, 4'b0000, 1, 0, 5'd0, 32'h0, 2'd3);
    tbl[19] = mk(0, 0, 4'b1001, A_DEF, D_DEF, 4'b0001, 1, 0, 5'd0, 32'h0, 2'd3);
    tbl[20] = mk(0, 0, 4'b0000, A_DEF, D_DEF, 4'b0000, 1, 1, 5'd1, D0, 2'd0);
    tbl[21] = mk(0, 0, 4'b1000, A_7,   D_DEF, 4'b1000, 1, 0, 5'd1, D0, 2'd0);
    tbl[22] = mk(1, 0, 4'b1001, A_7,   D_DEF, 4'b0000, 1, 1, 5'd7, D3, 2'd3);
    tbl[23] = mk(0, 0, 4'b1001, A_7,   D_DEF, 4'b0001, 1, 0, 5'd0, 32'h0, 2'd3);
    tbl[24] = mk(0, 0, 4'b0000, A_DEF, D_DEF, 4'b0000, 1, 1, 5'd1, D0, 2'd0);
    tbl[25] = mk(0, 0, 4'b0100, A_DEF, D_DEF, 4'b0100, 1, 0, 5'd1, D0, 2'd0);
    tbl[26] = mk(0, 0, 4'b0100, A_DEF, D_DEF, 4'b0100, 1, 1, 5'd3, D2, 2'd2);
    tbl[27] = mk(0, 0, 4'b0100, A_DEF, D_DEF, 4'b0100, 1, 1, 5'd3, D2, 2'd2);
    tbl[28] = mk(0, 0, 4'b0000, A_DEF, D_DEF, 4'b0000, 1, 1, 5'd3, D2, 2'd2);

    drive(1'b1, 1'b0, 4'b0000, 20'd0, 128'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].valid, tbl[i].addr, tbl[i].data);
      #4;
      chk($sformatf("vec%0d req_ready", i), 64'(bus.req_ready), 64'(tbl[i].exp_ready));
      if (tbl[i].chk_regs) begin
        chk($sformatf("vec%0d wr_ena", i), 64'(bus.wr_ena), 64'(tbl[i].exp_ena));
        chk($sformatf("vec%0d wr_addr", i), 64'(bus.wr_addr), 64'(tbl[i].exp_addr));
        chk($sformatf("vec%0d wr_data", i), 64'(bus.wr_data), 64'(tbl[i].exp_data));
        chk($sformatf("vec%0d last_grant", i), 64'(bus.last_grant), 64'(tbl[i].exp_last));
      end
      model_edge();
      @(posedge clk);
      #1;
    end

    for (int c = 0; c < 2000; c++) begin
      for (int r = 0; r < N; r++) begin
        ra[5*r +: 5]  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        rd[32*r +: 32] = $urandom;
      end
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0), 4'($urandom), ra, rd);
      #4;
      g = model_grant();
      exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk($sformatf("rnd%0d req_ready", c), 64'(bus.req_ready), 64'(exp_ready));
      chk($sformatf("rnd%0d wr_ena", c), 64'(bus.wr_ena), 64'(m_ena));
      chk($sformatf("rnd%0d wr_addr", c), 64'(bus.wr_addr), 64'(m_addr));
      chk($sformatf("rnd%0d wr_data", c), 64'(bus.wr_data), 64'(m_data));
      chk($sformatf("rnd%0d last_grant", c), 64'(bus.last_grant), 64'(m_last));
      model_edge();
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
